// File: rtl/systolic_pkg.sv
// Shared constants, state encoding and wavefront helper for the 4x4 systolic
// multiplier sequencer.
package systolic_pkg;

   localparam int DIM         = 4;
   localparam int FEED_CYCLES = 2 * DIM + 2;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      FEED  = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } seq_state_t;

   // Bit 2 flags that the lane sits inside its wavefront window at step t,
   // bits 1:0 give the element index (t - lane) to fetch for that lane.
   function automatic logic [2:0] skew_lookup(input logic [3:0] t, input logic [1:0] lane);
      logic [4:0] diff;
      diff = {1'b0, t} - {3'b000, lane};
      return {(diff < 5'(DIM)), diff[1:0]};
   endfunction

endpackage

// File: rtl/sys_mat_buf.sv
// 4x4 operand register file with whole-row writes and a combinational skewed
// read: row-skewed for the left wavefront, column-skewed for the up wavefront.
module sys_mat_buf
   import systolic_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter bit COL_SKEW   = 1'b0
) (
   input  logic                      clk_i,
   input  logic                      wr_en_i,
   input  logic [1:0]                wr_row_i,
   input  logic [DIM*DATA_WIDTH-1:0] wr_data_i,
   input  logic [3:0]                t_i,
   output logic [DIM*DATA_WIDTH-1:0] rd_data_o
);

   logic [DATA_WIDTH-1:0] mem [DIM][DIM];

   // Contents are deliberately not reset; software must load both matrices.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         for (int c = 0; c < DIM; c++) begin
            mem[wr_row_i][c] <= wr_data_i[c*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   for (genvar k = 0; k < DIM; k++) begin : g_lane
      logic [2:0] sel;
      assign sel = skew_lookup(t_i, 2'(k));

      if (COL_SKEW) begin : g_col
         assign rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] = sel[2] ? mem[sel[1:0]][k] : '0;
      end else begin : g_row
         assign rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] = sel[2] ? mem[k][sel[1:0]] : '0;
      end
   end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for the 4x4 output-stationary systolic array: buffers A and B,
// clears the accumulators, feeds skewed wavefronts and signals completion.
module systolic_seq_ctrl
   import systolic_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int DRAIN_CYCLES = 1
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      wr_en_i,
   input  logic                      wr_sel_i,
   input  logic [1:0]                wr_row_i,
   input  logic [DIM*DATA_WIDTH-1:0] wr_data_i,
   input  logic                      start_i,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      array_rst_no,
   output logic [DIM*DATA_WIDTH-1:0] left_o,
   output logic [DIM*DATA_WIDTH-1:0] up_o
);

   seq_state_t                state;
   logic [3:0]                cnt;
   logic                      wr_ok;
   logic [DIM*DATA_WIDTH-1:0] a_rd;
   logic [DIM*DATA_WIDTH-1:0] b_rd;

   assign wr_ok = wr_en_i & ~busy_o;

   sys_mat_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .COL_SKEW   (1'b0)
   ) u_buf_a (
      .clk_i     (clk_i),
      .wr_en_i   (wr_ok & ~wr_sel_i),
      .wr_row_i  (wr_row_i),
      .wr_data_i (wr_data_i),
      .t_i       (cnt),
      .rd_data_o (a_rd)
   );

   sys_mat_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .COL_SKEW   (1'b1)
   ) u_buf_b (
      .clk_i     (clk_i),
      .wr_en_i   (wr_ok & wr_sel_i),
      .wr_row_i  (wr_row_i),
      .wr_data_i (wr_data_i),
      .t_i       (cnt),
      .rd_data_o (b_rd)
   );

   // Outputs are registered from the current state, so each phase shows up on
   // the pins one cycle after its state is entered; busy_o alone is set at the
   // accepting edge. A start seen during the done pulse is dropped on purpose.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state        <= IDLE;
         cnt          <= '0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         array_rst_no <= 1'b0;
         left_o       <= '0;
         up_o         <= '0;
      end else begin
         done_o <= 1'b0;
         left_o <= '0;
         up_o   <= '0;
         case (state)
            IDLE: begin
               array_rst_no <= 1'b1;
               if (start_i && !busy_o && !done_o) begin
                  busy_o <= 1'b1;
                  state  <= CLEAR;
               end
            end
            CLEAR: begin
               array_rst_no <= 1'b0;
               cnt          <= '0;
               state        <= FEED;
            end
            FEED: begin
               array_rst_no <= 1'b1;
               left_o       <= a_rd;
               up_o         <= b_rd;
               if (cnt == 4'(FEED_CYCLES - 1)) begin
                  cnt   <= '0;
                  state <= DRAIN;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            DRAIN: begin
               if (cnt == 4'(DRAIN_CYCLES - 1)) begin
                  cnt   <= '0;
                  state <= DONE;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            DONE: begin
               done_o <= 1'b1;
               busy_o <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
